// File: rtl/n4_pkg.sv
// Shared constants and types for the C1S2 result buffer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package n4_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 32;
    localparam int NRD    = 5;
    localparam int CNT_W  = 16;

    // C1S2 output geometry: 6 pooled maps of 14x14 words each.
    localparam int C1S2_MAPS      = 6;
    localparam int C1S2_MAP_H     = 14;
    localparam int C1S2_MAP_W     = 14;
    localparam int C1S2_OUT_DEPTH = C1S2_MAPS * C1S2_MAP_H * C1S2_MAP_W;

    typedef enum logic [1:0] {
        BUF_IDLE  = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_READY = 2'd2
    } buf_state_t;

    // Bit positions inside err_flags.
    localparam int ERR_WR_READY   = 0;
    localparam int ERR_ADDR_RANGE = 1;
    localparam int ERR_CNT        = 2;

endpackage

// File: rtl/n4_buf_lane.sv
// One read lane of the result buffer: full-frame memory, broadcast write, gated registered read.
// Latency: read data valid one cycle after the address is sampled.
// Backpressure: none; out-of-range or not-ready reads return zero.
module n4_buf_lane
    import n4_pkg::*;
#(
    parameter int DEPTH  = C1S2_OUT_DEPTH,
    parameter int DW     = DATA_W,
    parameter int AW     = ADDR_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [DW-1:0]    i_wr_dat,
    input  logic             i_rd_ok,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [DW-1:0]    o_rd_dat
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DW-1:0]    r_rd_dat;
    logic             w_rd_hit;
    logic [IDX_W-1:0] w_rd_idx;

    // The range check runs on the full address so aliases of the low bits never hit.
    assign w_rd_hit = i_rd_ok && (i_rd_addr < AW'(DEPTH));
    assign w_rd_idx = w_rd_hit ? i_rd_addr[IDX_W-1:0] : '0;

    // Memory is left uncleared by reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    // Registered read port; returns zero unless the frame is ready and the address valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
        end else begin
            r_rd_dat <= w_rd_hit ? r_mem[w_rd_idx] : '0;
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/c1s2_result_buf.sv
// Captures one C1S2 output frame and serves it to C3S4 on NRD independent read lanes.
// Latency: buf_ready rises the cycle after prod_fin; reads return one cycle after the address.
// Backpressure: none; writes in READY and out-of-range writes are dropped and flagged.
module c1s2_result_buf
    import n4_pkg::*;
#(
    parameter int DATA_W = n4_pkg::DATA_W,
    parameter int ADDR_W = n4_pkg::ADDR_W,
    parameter int DEPTH  = C1S2_OUT_DEPTH,
    parameter int NRD    = n4_pkg::NRD,
    parameter int CNT_W  = n4_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_in,
    input  logic [ADDR_W-1:0]     wr_addr_in,
    input  logic [DATA_W-1:0]     wr_data_in,
    input  logic                  prod_fin,
    input  logic [ADDR_W*NRD-1:0] rd_addr_in_5P,
    output logic [DATA_W*NRD-1:0] rd_data_out_5P,
    output logic                  buf_ready,
    input  logic                  cons_fin,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [2:0]            err_flags
);

    localparam int IDX_W = $clog2(DEPTH);

    buf_state_t       r_state;
    logic             r_ready;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_err;

    logic             w_not_ready;
    logic             w_addr_ok;
    logic             w_wr_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_bad;
    logic [IDX_W-1:0] w_wr_idx;

    assign w_not_ready = (r_state != BUF_READY);
    assign w_addr_ok   = (wr_addr_in < ADDR_W'(DEPTH));
    assign w_wr_ok     = rst_n && wr_en_in && w_not_ready && w_addr_ok;
    assign w_wr_idx    = wr_addr_in[IDX_W-1:0];

    // Saturating count; the closing compare uses the count including this cycle's write.
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_next = w_wr_ok ? w_cnt_inc : r_cnt;
    assign w_cnt_bad  = (w_cnt_next != CNT_W'(DEPTH));

    // Fill/ready/release FSM with the write counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BUF_IDLE;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_err   <= '0;
        end else begin
            if (wr_en_in && !w_not_ready) begin
                r_err[ERR_WR_READY] <= 1'b1;
            end
            if (wr_en_in && w_not_ready && !w_addr_ok) begin
                r_err[ERR_ADDR_RANGE] <= 1'b1;
            end
            case (r_state)
                BUF_IDLE, BUF_FILL: begin
                    r_cnt <= w_cnt_next;
                    if (prod_fin) begin
                        r_state <= BUF_READY;
                        r_ready <= 1'b1;
                        if (w_cnt_bad) begin
                            r_err[ERR_CNT] <= 1'b1;
                        end
                    end else if (w_wr_ok) begin
                        r_state <= BUF_FILL;
                    end
                end
                BUF_READY: begin
                    // Release takes priority; a late prod_fin here is meaningless.
                    if (cons_fin) begin
                        r_state <= BUF_IDLE;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= BUF_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // One lane per read port, all fed by the same write stream.
    for (genvar p = 0; p < NRD; p++) begin : g_lane
        n4_buf_lane #(
            .DEPTH (DEPTH),
            .DW    (DATA_W),
            .AW    (ADDR_W),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_wr_ok),
            .i_wr_idx  (w_wr_idx),
            .i_wr_dat  (wr_data_in),
            .i_rd_ok   (!w_not_ready),
            .i_rd_addr (rd_addr_in_5P[ADDR_W*p +: ADDR_W]),
            .o_rd_dat  (rd_data_out_5P[DATA_W*p +: DATA_W])
        );
    end

    assign buf_ready = r_ready;
    assign wr_cnt    = r_cnt;
    assign err_flags = r_err;

endmodule
